// File: rtl/ifetch_queue_if.sv
// Fetch-unit bus bundle: cache lookup/return channel and decode handshake.
// Signal suffixes are seen from the fetch unit, which uses the master modport.
interface ifetch_queue_if #(
   parameter int WIDTH   = 32,
   parameter int ADDRESS = 20
);
   // cache side
   logic               lookup_o;
   logic [ADDRESS-1:0] pc_nxt_o;
   logic               busy_i;
   logic               miss_i;
   logic               ready_i;
   logic [WIDTH-1:0]   data_i;
   // decode side
   logic               dec_valid_o;
   logic               dec_ready_i;
   logic [WIDTH-1:0]   dec_instr_o;
   logic [ADDRESS-1:0] dec_pc_o;

   modport master (
      output lookup_o, pc_nxt_o, dec_valid_o, dec_instr_o, dec_pc_o,
      input  busy_i, miss_i, ready_i, data_i, dec_ready_i
   );

   modport slave (
      input  lookup_o, pc_nxt_o, dec_valid_o, dec_instr_o, dec_pc_o,
      output busy_i, miss_i, ready_i, data_i, dec_ready_i
   );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction-fetch front end: sequential lookups to the I-cache, PC tagging of
// returned words, a small in-order queue toward decode, and redirect flushing.
module ifetch_queue #(
   parameter int                   WIDTH      = 32,
   parameter int                   ADDRESS    = 20,
   parameter int                   DEPTH_LOG2 = 2,
   parameter logic [ADDRESS-1:0]   RESET_PC   = '0
) (
   input  logic               clock_i,
   input  logic               reset_ni,
   input  logic               enable_i,
   input  logic               redirect_i,
   input  logic [ADDRESS-1:0] redirect_pc_i,
   ifetch_queue_if.master     bus,
   output logic [15:0]        miss_cnt_o
);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int CW    = DEPTH_LOG2 + 1;

   logic [ADDRESS-1:0]    fpc_q, fpc_d;
   logic [ADDRESS-1:0]    rpc_q, rpc_d;
   logic [CW-1:0]         infl_q, infl_d;
   logic [CW-1:0]         drop_q, drop_d;
   logic [CW-1:0]         occ_q, occ_d;
   logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
   logic [15:0]           miss_cnt_q;

   logic [ADDRESS-1:0]    pc_rd   [DEPTH];
   logic [WIDTH-1:0]      instr_rd[DEPTH];

   logic [CW:0]           room_used;
   logic                  accept;
   logic                  push;
   logic                  pop;

   // Queued plus outstanding entries; a lookup is only issued when its
   // response is guaranteed a queue slot.
   assign room_used = {1'b0, occ_q} + {1'b0, infl_q};

   assign bus.lookup_o    = reset_ni & enable_i & ~redirect_i &
                            (room_used < (CW+1)'(DEPTH));
   assign bus.pc_nxt_o    = fpc_q;
   assign bus.dec_valid_o = (occ_q != '0);
   assign bus.dec_pc_o    = pc_rd[rd_ptr_q];
   assign bus.dec_instr_o = instr_rd[rd_ptr_q];
   assign miss_cnt_o      = miss_cnt_q;

   assign accept = bus.lookup_o & ~bus.busy_i;
   // Responses owed to a flushed path, or arriving in the redirect cycle, are dropped.
   assign push   = bus.ready_i & (drop_q == '0) & ~redirect_i;
   assign pop    = bus.dec_valid_o & bus.dec_ready_i & ~redirect_i;

   // Next-state for PCs, counters and pointers; redirect overrides the queue.
   always_comb begin
      fpc_d    = fpc_q;
      rpc_d    = rpc_q;
      drop_d   = drop_q;
      occ_d    = occ_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      infl_d   = infl_q + CW'(accept) - CW'(bus.ready_i);
      if (accept) begin
         fpc_d = fpc_q + ADDRESS'(1);
      end
      if (redirect_i) begin
         fpc_d    = redirect_pc_i;
         rpc_d    = redirect_pc_i;
         // Every fetch still outstanding after this edge belongs to the old
         // path. infl already counts the ones pending drop, so drop never
         // exceeds infl and back-to-back redirects recompute it cleanly.
         drop_d   = infl_q - CW'(bus.ready_i);
         occ_d    = '0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (bus.ready_i && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
         end
         if (push) begin
            rpc_d    = rpc_q + ADDRESS'(1);
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
         end
         occ_d = occ_q + CW'(push) - CW'(pop);
      end
   end

   // State register for PCs, counters and queue pointers.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         fpc_q    <= RESET_PC;
         rpc_q    <= RESET_PC;
         infl_q   <= '0;
         drop_q   <= '0;
         occ_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         fpc_q    <= fpc_d;
         rpc_q    <= rpc_d;
         infl_q   <= infl_d;
         drop_q   <= drop_d;
         occ_q    <= occ_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Queue storage: one {pc, instr} register per slot, read through a mux.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [ADDRESS-1:0] pc_q;
      logic [WIDTH-1:0]   instr_q;

      // Capture the tagged response when the write pointer selects this slot.
      always_ff @(posedge clock_i or negedge reset_ni) begin
         if (!reset_ni) begin
            pc_q    <= '0;
            instr_q <= '0;
         end else if (push && (wr_ptr_q == DEPTH_LOG2'(gi))) begin
            pc_q    <= rpc_q;
            instr_q <= bus.data_i;
         end
      end

      assign pc_rd[gi]    = pc_q;
      assign instr_rd[gi] = instr_q;
   end

   // Saturating miss statistics counter.
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         miss_cnt_q <= '0;
      end else if (bus.miss_i && (miss_cnt_q != 16'hFFFF)) begin
         miss_cnt_q <= miss_cnt_q + 16'd1;
      end
   end
endmodule

// File: tb/tb_ifetch_queue.sv
// Randomised bench for ifetch_queue: a cache model answers lookups in order,
// a path-epoch reference model predicts decode output into a scoreboard, and a
// monitor compares whatever decode accepts.
`timescale 1ns/1ps
module tb_ifetch_queue;
   localparam int WIDTH   = 32;
   localparam int ADDRESS = 20;

   logic               clock_i  = 1'b0;
   logic               reset_ni = 1'b0;
   logic               enable_i = 1'b0;
   logic               redirect_i = 1'b0;
   logic [ADDRESS-1:0] redirect_pc_i = '0;
   logic [15:0]        miss_cnt_o;

   ifetch_queue_if #(.WIDTH(WIDTH), .ADDRESS(ADDRESS)) bus ();

   ifetch_queue #(
      .WIDTH(WIDTH), .ADDRESS(ADDRESS), .DEPTH_LOG2(2), .RESET_PC(20'h0)
   ) dut (
      .clock_i(clock_i),
      .reset_ni(reset_ni),
      .enable_i(enable_i),
      .redirect_i(redirect_i),
      .redirect_pc_i(redirect_pc_i),
      .bus(bus),
      .miss_cnt_o(miss_cnt_o)
   );

   always #5 clock_i = ~clock_i;

   typedef struct { logic [19:0] pc; int epoch; int due; } req_t;
   typedef struct { logic [19:0] pc; logic [31:0] instr; } ent_t;

   req_t        pend[$];   // lookups the cache still owes, in order
   ent_t        expq[$];   // what decode should see, in order
   logic [19:0] m_fpc;
   int          epoch;
   int          cyc;
   logic [15:0] m_miss;
   int          n_cmp, n_bad, n_pop, n_acc;
   int          k_en, k_busy, k_dr, k_redir, k_miss, k_lmin, k_lmax;
   bit          force_redir, hold_ready;
   logic [19:0] force_pc;

   function automatic logic [31:0] mem_word(input logic [19:0] pc);
      return 32'h9E3779B9 * {12'h0, pc} + 32'h12345678;
   endfunction

   function automatic bit pct(input int p);
      return int'($urandom_range(0, 99)) < p;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", name, cyc, act, req);
      end
   endtask

   task automatic set_knobs(input int en, input int busy, input int dr, input int redir,
                            input int miss, input int lmin, input int lmax);
      k_en = en; k_busy = busy; k_dr = dr; k_redir = redir;
      k_miss = miss; k_lmin = lmin; k_lmax = lmax;
   endtask

   // One clock cycle: drive at the falling edge, check fetch side, update model at the rising edge.
   task automatic cycle();
      bit   exp_lookup, do_acc;
      req_t r;
      enable_i        = pct(k_en);
      bus.busy_i      = pct(k_busy);
      bus.dec_ready_i = pct(k_dr);
      redirect_i      = force_redir || pct(k_redir);
      redirect_pc_i   = force_redir ? force_pc : 20'($urandom);
      bus.ready_i     = (pend.size() > 0) && (pend[0].due <= cyc) && !hold_ready;
      bus.data_i      = bus.ready_i ? mem_word(pend[0].pc) : $urandom;
      bus.miss_i      = pct(k_miss);
      #1;
      exp_lookup = enable_i && !redirect_i && ((expq.size() + pend.size()) < 4);
      chk("lookup", 32'(bus.lookup_o), 32'(exp_lookup));
      chk("pc_nxt", 32'(bus.pc_nxt_o), 32'(m_fpc));
      do_acc = exp_lookup && !bus.busy_i;
      if (bus.lookup_o && !bus.busy_i) n_acc++;
      @(posedge clock_i);
      if (bus.miss_i && m_miss != 16'hFFFF) m_miss++;
      if (bus.ready_i) begin
         r = pend.pop_front();
         if (!redirect_i && r.epoch == epoch)
            expq.push_back('{pc: r.pc, instr: mem_word(r.pc)});
      end
      if (redirect_i) begin
         epoch++;
         expq.delete();
         m_fpc = redirect_pc_i;
      end else if (do_acc) begin
         pend.push_back('{pc: m_fpc, epoch: epoch, due: cyc + int'($urandom_range(k_lmin, k_lmax))});
         m_fpc = m_fpc + 20'd1;
      end
      cyc++;
      force_redir = 1'b0;
      @(negedge clock_i);
   endtask

   // Entered and left at a falling edge; the cache model is reset with the DUT.
   task automatic do_reset();
      reset_ni = 1'b0;
      enable_i = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
      bus.busy_i = 1'b0; bus.ready_i = 1'b0; bus.data_i = '0;
      bus.miss_i = 1'b0; bus.dec_ready_i = 1'b0;
      #1;
      chk("rst_lookup",    32'(bus.lookup_o),    32'h0);
      chk("rst_pc_nxt",    32'(bus.pc_nxt_o),    32'h0);
      chk("rst_dec_valid", 32'(bus.dec_valid_o), 32'h0);
      chk("rst_dec_instr", bus.dec_instr_o,      32'h0);
      chk("rst_dec_pc",    32'(bus.dec_pc_o),    32'h0);
      chk("rst_miss_cnt",  32'(miss_cnt_o),      32'h0);
      pend.delete(); expq.delete();
      m_fpc = 20'h0; m_miss = 16'h0; epoch++;
      @(negedge clock_i);
      @(negedge clock_i);
      chk("rst_lookup_hold", 32'(bus.lookup_o), 32'h0);
      enable_i = 1'b0;
      reset_ni = 1'b1;
   endtask

   // Monitor: checks decode output against the scoreboard every cycle.
   initial begin
      ent_t e;
      forever begin
         @(negedge clock_i);
         #2;
         if (reset_ni) begin
            chk("dec_valid", 32'(bus.dec_valid_o), 32'(expq.size() != 0));
            chk("miss_cnt",  32'(miss_cnt_o),      32'(m_miss));
            if (bus.dec_valid_o && bus.dec_ready_i) n_pop++;
            if (expq.size() != 0 && bus.dec_ready_i && !redirect_i) begin
               e = expq.pop_front();
               chk("dec_pc",    32'(bus.dec_pc_o), 32'(e.pc));
               chk("dec_instr", bus.dec_instr_o,   e.instr);
            end
         end
      end
   end

   initial begin
      #1200000;
      $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      n_cmp = 0; n_bad = 0; n_pop = 0; n_acc = 0; cyc = 0; epoch = 0;
      m_fpc = '0; m_miss = '0; force_redir = 1'b0; hold_ready = 1'b0; force_pc = '0;
      set_knobs(0, 0, 0, 0, 0, 1, 1);
      bus.busy_i = 1'b0; bus.ready_i = 1'b0; bus.data_i = '0;
      bus.miss_i = 1'b0; bus.dec_ready_i = 1'b0;
      @(negedge clock_i);

      // reset, then streaming with a zero-wait cache and decode always ready
      do_reset();
      set_knobs(100, 0, 100, 0, 0, 1, 1);
      n_pop = 0;
      repeat (20) cycle();
      chk("stream_rate", 32'(n_pop), 32'd18);

      // decode backpressure: exactly four lookups, then resume at pc 4
      do_reset();
      set_knobs(100, 0, 0, 0, 0, 1, 1);
      n_acc = 0;
      repeat (10) cycle();
      chk("bp_accepts", 32'(n_acc), 32'd4);
      chk("bp_full_valid", 32'(bus.dec_valid_o), 32'h1);
      k_dr = 100;
      repeat (20) cycle();

      // busy stall at pc 0x10
      do_reset();
      set_knobs(100, 0, 100, 0, 0, 1, 1);
      for (int i = 0; i < 100 && m_fpc != 20'h10; i++) cycle();
      k_busy = 100;
      repeat (5) begin
         cycle();
         chk("busy_hold", 32'(bus.pc_nxt_o), 32'h10);
      end
      k_busy = 0;
      repeat (10) cycle();

      // redirect with 2 in flight and 1 queued; variant 1 has ready_i coincident
      for (int v = 0; v < 2; v++) begin
         do_reset();
         set_knobs(100, 0, 0, 0, 0, 2, 2);
         for (int i = 0; i < 20 && !(expq.size() == 1 && pend.size() == 2); i++) cycle();
         force_redir = 1'b1; force_pc = 20'h80; hold_ready = (v == 0);
         cycle();
         hold_ready = 1'b0;
         chk("rd_flush_valid", 32'(bus.dec_valid_o), 32'h0);
         set_knobs(100, 0, 100, 0, 0, 1, 1);
         for (int i = 0; i < 20 && !bus.dec_valid_o; i++) cycle();
         chk("rd_first_pc",    32'(bus.dec_pc_o), 32'h80);
         chk("rd_first_instr", bus.dec_instr_o,   mem_word(20'h80));
         repeat (5) cycle();
      end

      // PC wrap
      set_knobs(100, 0, 100, 0, 0, 1, 1);
      force_redir = 1'b1; force_pc = 20'hFFFFF;
      cycle();
      for (int i = 0; i < 20 && !bus.dec_valid_o; i++) cycle();
      chk("wrap_pc_hi", 32'(bus.dec_pc_o), 32'hFFFFF);
      cycle();
      chk("wrap_valid", 32'(bus.dec_valid_o), 32'h1);
      chk("wrap_pc_lo", 32'(bus.dec_pc_o), 32'h0);

      // random traffic, with one reset mid-stream
      do_reset();
      for (int blk = 0; blk < 15; blk++) begin
         if (blk == 7) do_reset();
         set_knobs(int'($urandom_range(50, 100)), int'($urandom_range(0, 50)),
                   int'($urandom_range(20, 100)), int'($urandom_range(0, 8)),
                   30, 1, int'($urandom_range(1, 5)));
         repeat (200) cycle();
      end

      // miss counter saturation
      set_knobs(0, 0, 100, 0, 100, 1, 1);
      repeat (70000) cycle();
      chk("miss_sat", 32'(miss_cnt_o), 32'hFFFF);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
